// File: rtl/mrd_pkg.sv
// Shared constants and types for the mixed-radix DFT output streamer.
// Holds default sizes, the factor type and the streamer FSM encoding.
package mrd_pkg;

  localparam int NFMAX = 6;
  localparam int AW    = 11;
  localparam int DW    = 18;

  typedef logic [2:0]    factor_t;
  typedef logic [AW-1:0] addr_t;
  typedef logic [1:0]    state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SETUP = 2'd1;
  localparam state_t ST_RUN   = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/mrd_digitrev_cnt.sv
// Mixed-radix digit counter with an incrementally kept digit-reversed address.
// Ports: clk/rst, load (clear), step (advance), nf_i/f_i factor list,
// q_i weights, w_i wrap decrements -> addr_o current address, last_o all digits at max.
module mrd_digitrev_cnt
  import mrd_pkg::*;
#(
  parameter int AW    = mrd_pkg::AW,
  parameter int NFMAX = mrd_pkg::NFMAX
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       step,
  input  logic [2:0]                 nf_i,
  input  factor_t [0:NFMAX-1]        f_i,
  input  logic [NFMAX-1:0][AW-1:0]   q_i,
  input  logic [NFMAX-1:0][AW-1:0]   w_i,
  output logic [AW-1:0]              addr_o,
  output logic                       last_o
);

  factor_t [0:NFMAX-1] c_q, c_d;
  logic [AW-1:0]       a_q, a_d;
  logic                carry;

  // Digit nf_i-1 is the fastest; a carry ripples toward digit 0.
  always_comb begin
    c_d   = c_q;
    a_d   = a_q;
    carry = 1'b1;
    for (int i = NFMAX - 1; i >= 0; i--) begin
      if (carry && (i < int'(nf_i))) begin
        if (c_q[i] == f_i[i] - 3'd1) begin
          c_d[i] = '0;
          a_d    = a_d - w_i[i];
        end else begin
          c_d[i] = c_q[i] + 3'd1;
          a_d    = a_d + q_i[i];
          carry  = 1'b0;
        end
      end
    end
  end

  always_comb begin
    last_o = 1'b1;
    for (int i = 0; i < NFMAX; i++) begin
      if ((i < int'(nf_i)) && (c_q[i] != f_i[i] - 3'd1)) begin
        last_o = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q <= '0;
      a_q <= '0;
    end else if (load) begin
      c_q <= '0;
      a_q <= '0;
    end else if (step) begin
      c_q <= c_d;
      a_q <= a_d;
    end
  end

  assign addr_o = a_q;

endmodule

// File: rtl/mrd_st_source.sv
// Streams a finished mixed-radix DFT frame out of result memory in natural order.
// Ports: start/size_in/exp_in/NumOfFactors/Nf frame setup; busy/err status;
// rd_en/rd_addr/rd_real/rd_imag memory read; valid/sop/eop/dout_*/exp/size/done stream.
module mrd_st_source
  import mrd_pkg::*;
#(
  parameter int DW     = mrd_pkg::DW,
  parameter int AW     = mrd_pkg::AW,
  parameter int NFMAX  = mrd_pkg::NFMAX,
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [5:0]           size_in,
  input  logic [3:0]           exp_in,
  input  logic [2:0]           NumOfFactors,
  input  factor_t [0:NFMAX-1]  Nf,
  output logic                 busy,
  output logic                 err,
  output logic                 rd_en,
  output logic [AW-1:0]        rd_addr,
  input  logic [DW-1:0]        rd_real,
  input  logic [DW-1:0]        rd_imag,
  output logic                 valid,
  output logic                 sop,
  output logic                 eop,
  output logic [DW-1:0]        dout_real,
  output logic [DW-1:0]        dout_imag,
  output logic [3:0]           exp,
  output logic [5:0]           size,
  output logic                 done
);

  localparam int SW = $clog2(NFMAX);

  state_t                   st_q, st_d;
  logic [2:0]               nf_q;
  factor_t [0:NFMAX-1]      f_q;
  logic [NFMAX-1:0][AW-1:0] q_q, w_q;
  logic [SW-1:0]            sc_q;
  logic [2:0]               dc_q;
  logic                     first_q;
  logic                     err_q;
  logic [5:0]               size_lat_q, size_q;
  logic [3:0]               exp_lat_q, exp_q;
  logic [RD_LAT-1:0]        vld_p, sop_p, eop_p;

  logic          ok, accept, setup_end, last;
  logic [AW-1:0] mq, mw, cnt_addr;

  always_comb begin
    ok = (NumOfFactors != 3'd0) && (int'(NumOfFactors) <= NFMAX);
    for (int i = 0; i < NFMAX; i++) begin
      if ((i < int'(NumOfFactors)) && ((Nf[i] < 3'd2) || (Nf[i] > 3'd5))) begin
        ok = 1'b0;
      end
    end
  end

  assign accept    = start && (st_q == ST_IDLE) && ok;
  assign setup_end = (st_q == ST_SETUP) && (sc_q == SW'(NFMAX - 1));

  // One weight per SETUP cycle: Q[k+1] = Q[k]*Nf[k], W[k] = Q[k]*(Nf[k]-1).
  assign mq = q_q[sc_q] * AW'(f_q[sc_q]);
  assign mw = q_q[sc_q] * AW'(f_q[sc_q] - 3'd1);

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE:  if (accept) st_d = ST_SETUP;
      ST_SETUP: if (setup_end) st_d = ST_RUN;
      ST_RUN:   if (last) st_d = ST_DRAIN;
      ST_DRAIN: if (dc_q == 3'(RD_LAT - 1)) st_d = ST_IDLE;
      default:  st_d = ST_IDLE;
    endcase
  end

  mrd_digitrev_cnt #(
    .AW    (AW),
    .NFMAX (NFMAX)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (setup_end),
    .step   (rd_en),
    .nf_i   (nf_q),
    .f_i    (f_q),
    .q_i    (q_q),
    .w_i    (w_q),
    .addr_o (cnt_addr),
    .last_o (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= ST_IDLE;
      nf_q       <= '0;
      f_q        <= '0;
      q_q        <= '0;
      w_q        <= '0;
      sc_q       <= '0;
      dc_q       <= '0;
      first_q    <= 1'b0;
      err_q      <= 1'b0;
      size_lat_q <= '0;
      exp_lat_q  <= '0;
      size_q     <= '0;
      exp_q      <= '0;
      vld_p      <= '0;
      sop_p      <= '0;
      eop_p      <= '0;
    end else begin
      st_q    <= st_d;
      err_q   <= start && (st_q == ST_IDLE) && !ok;
      first_q <= (st_q == ST_SETUP);
      if (accept) begin
        nf_q       <= NumOfFactors;
        f_q        <= Nf;
        size_lat_q <= size_in;
        exp_lat_q  <= exp_in;
        q_q[0]     <= AW'(1);
        sc_q       <= '0;
      end
      if (st_q == ST_SETUP) begin
        sc_q <= sc_q + 1'b1;
        for (int i = 0; i < NFMAX; i++) begin
          if (int'(sc_q) == i) w_q[i] <= mw;
          if (int'(sc_q) + 1 == i) q_q[i] <= mq;
        end
      end
      if (st_q == ST_DRAIN) dc_q <= dc_q + 3'd1;
      else dc_q <= '0;
      vld_p[0] <= rd_en;
      sop_p[0] <= rd_en && first_q;
      eop_p[0] <= rd_en && last;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        sop_p[i] <= sop_p[i-1];
        eop_p[i] <= eop_p[i-1];
      end
      exp_q  <= exp;
      size_q <= size;
    end
  end

  assign busy    = (st_q != ST_IDLE);
  assign err     = err_q;
  assign rd_en   = (st_q == ST_RUN);
  assign rd_addr = rd_en ? cnt_addr : '0;

  assign valid     = vld_p[RD_LAT-1];
  assign sop       = sop_p[RD_LAT-1];
  assign eop       = eop_p[RD_LAT-1];
  assign done      = eop;
  assign dout_real = valid ? rd_real : '0;
  assign dout_imag = valid ? rd_imag : '0;

  // Frame tags switch over exactly on the sop sample, then hold.
  assign exp  = sop ? exp_lat_q : exp_q;
  assign size = sop ? size_lat_q : size_q;

endmodule

// File: tb/tb_mrd_st_source.sv
// Directed self-checking bench for mrd_st_source.
// Memory model with a two-cycle read pipe; expected order from a mixed-radix model.
module tb_mrd_st_source;

  localparam int DW = 18;
  localparam int AW = 11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [5:0]       size_in = '0;
  logic [3:0]       exp_in = '0;
  logic [2:0]       NumOfFactors = '0;
  logic [0:5][2:0]  Nf = '0;
  logic             busy, err, rd_en, valid, sop, eop, done;
  logic [AW-1:0]    rd_addr;
  logic [DW-1:0]    rd_real, rd_imag, dout_real, dout_imag;
  logic [3:0]       o_exp;
  logic [5:0]       o_size;

  mrd_st_source #(.DW(DW), .AW(AW), .NFMAX(6), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .size_in(size_in),
    .exp_in(exp_in), .NumOfFactors(NumOfFactors), .Nf(Nf),
    .busy(busy), .err(err), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_real(rd_real), .rd_imag(rd_imag), .valid(valid),
    .sop(sop), .eop(eop), .dout_real(dout_real),
    .dout_imag(dout_imag), .exp(o_exp), .size(o_size), .done(done)
  );

  always #5 clk = ~clk;

  int mem_r [0:2047];
  int mem_i [0:2047];
  logic [AW-1:0] ap1 = '0, ap2 = '0;

  always @(posedge clk) begin
    ap1 <= rd_addr;
    ap2 <= ap1;
  end

  assign rd_real = DW'(mem_r[ap2]);
  assign rd_imag = DW'(mem_i[ap2]);

  int ncmp = 0;
  int nerr = 0;

  int got_r [0:1299];
  int got_i [0:1299];
  int got_cnt, first_rd, first_vld, last_vld, sop_cyc, eop_cyc;
  int done_cyc, busy_low, nsop, neop, err_seen, nz_idle, timed_out;
  int exp_sop, size_sop, exp_eop;
  int exp1 [12] = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11};

  task automatic chk(input string tag, input longint obs, input longint expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int model_addr(int n, int nfn, logic [0:5][2:0] f);
    int rem = n;
    int addr = 0;
    int q;
    for (int i = nfn - 1; i >= 0; i--) begin
      q = 1;
      for (int j = 0; j < i; j++) q = q * int'(f[j]);
      addr = addr + (rem % int'(f[i])) * q;
      rem = rem / int'(f[i]);
    end
    return addr;
  endfunction

  task automatic fill_lin();
    for (int a = 0; a < 2048; a++) begin
      mem_r[a] = a;
      mem_i[a] = a + 100;
    end
  endtask

  task automatic fill_rand();
    for (int a = 0; a < 2048; a++) begin
      mem_r[a] = int'($urandom_range(0, 262143)) - 131072;
      mem_i[a] = int'($urandom_range(0, 262143)) - 131072;
    end
  endtask

  // Entered and left at a negedge; start is driven in the calling cycle.
  task automatic run_frame(input logic [2:0] nfn, input logic [0:5][2:0] f,
                           input logic [5:0] sz, input logic [3:0] ex,
                           input int mid_at);
    int cyc = 0;
    bit seen_eop = 0;
    Nf = f; NumOfFactors = nfn; size_in = sz; exp_in = ex; start = 1'b1;
    got_cnt = 0; first_rd = -1; first_vld = -1; last_vld = -1;
    sop_cyc = -1; eop_cyc = -1; done_cyc = -1; busy_low = -1;
    nsop = 0; neop = 0; err_seen = 0; nz_idle = 0; timed_out = 0;
    exp_sop = -1; size_sop = -1; exp_eop = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (mid_at > 0 && cyc == mid_at) begin
        start = 1'b1; NumOfFactors = 3'd3;
        Nf = {3'd5, 3'd5, 3'd5, 3'd0, 3'd0, 3'd0};
      end
      if (mid_at > 0 && cyc == mid_at + 1) start = 1'b0;
      if (rd_en && first_rd < 0) first_rd = cyc;
      if (err) err_seen = 1;
      if (!valid && (dout_real != 0 || dout_imag != 0)) nz_idle = 1;
      if (valid) begin
        if (first_vld < 0) first_vld = cyc;
        last_vld = cyc;
        if (got_cnt < 1300) begin
          got_r[got_cnt] = int'($signed(dout_real));
          got_i[got_cnt] = int'($signed(dout_imag));
        end
        got_cnt++;
      end
      if (sop) begin
        nsop++; sop_cyc = cyc;
        exp_sop = int'(o_exp); size_sop = int'(o_size);
      end
      if (eop) begin
        neop++; eop_cyc = cyc; seen_eop = 1;
        exp_eop = int'(o_exp);
      end
      if (done) done_cyc = cyc;
      if (seen_eop && !busy) begin
        busy_low = cyc;
        break;
      end
      if (cyc > 3000) begin
        timed_out = 1;
        break;
      end
    end
  endtask

  task automatic chk_frame(input string tag, input int n, input int nfn,
                           input logic [0:5][2:0] f, input int ex, input int sz);
    int a;
    chk({tag, "_timeout"}, timed_out, 0);
    chk({tag, "_count"}, got_cnt, n);
    chk({tag, "_contig"}, last_vld - first_vld + 1, n);
    chk({tag, "_first_rd"}, first_rd, 7);
    chk({tag, "_first_vld"}, first_vld, 9);
    chk({tag, "_nsop"}, nsop, 1);
    chk({tag, "_neop"}, neop, 1);
    chk({tag, "_sop_pos"}, sop_cyc, first_vld);
    chk({tag, "_eop_pos"}, eop_cyc, last_vld);
    chk({tag, "_done_pos"}, done_cyc, eop_cyc);
    chk({tag, "_busy_low"}, busy_low, eop_cyc + 1);
    chk({tag, "_err"}, err_seen, 0);
    chk({tag, "_idle_zero"}, nz_idle, 0);
    chk({tag, "_exp_sop"}, exp_sop, ex);
    chk({tag, "_size_sop"}, size_sop, sz);
    chk({tag, "_exp_eop"}, exp_eop, ex);
    for (int k = 0; k < n && k < got_cnt && k < 1300; k++) begin
      a = model_addr(k, nfn, f);
      chk({tag, "_re"}, got_r[k], mem_r[a]);
      chk({tag, "_im"}, got_i[k], mem_i[a]);
    end
  endtask

  initial begin
    logic [0:5][2:0] f34;
    logic [0:5][2:0] f5;
    logic [0:5][2:0] f600;
    int bad;
    int nv;
    f34  = {3'd3, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0};
    f5   = {3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    f600 = {3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd0};
    fill_lin();

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_exp", o_exp, 0);
    chk("rst_size", o_size, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    // 3x4 frame against the hand table
    run_frame(3'd2, f34, 6'd10, 4'd3, 0);
    chk_frame("t1", 12, 2, f34, 3, 10);
    for (int k = 0; k < 12; k++) begin
      chk("t1_tab_re", got_r[k], exp1[k]);
      chk("t1_tab_im", got_i[k], exp1[k] + 100);
    end

    // start while busy ignored; next start lands on the cycle busy drops
    run_frame(3'd2, f34, 6'd12, 4'd5, 20);
    chk_frame("t4", 12, 2, f34, 5, 12);
    for (int k = 0; k < 12; k++) chk("t4_tab_re", got_r[k], exp1[k]);
    run_frame(3'd1, f5, 6'd20, 4'd7, 0);
    chk_frame("nf1", 5, 1, f5, 7, 20);
    chk("nf1_sop_ne_eop", (sop_cyc != eop_cyc), 1);

    // N = 600, random data
    fill_rand();
    run_frame(3'd5, f600, 6'd33, 4'd9, 0);
    chk_frame("t2", 600, 5, f600, 9, 33);

    // rejected factor lists
    for (int t = 0; t < 2; t++) begin
      NumOfFactors = (t == 0) ? 3'd0 : 3'd2;
      Nf = (t == 0) ? f34 : {3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t5_err_pulse", err, 1);
      chk("t5_busy", busy, 0);
      @(negedge clk);
      chk("t5_err_clear", err, 0);
      bad = 0;
      repeat (12) begin
        @(negedge clk);
        if (rd_en || busy || err || valid) bad = 1;
      end
      chk("t5_quiet", bad, 0);
    end

    // reset on the 5th sample of a 12-sample frame
    fill_lin();
    NumOfFactors = 3'd2; Nf = f34; size_in = 6'd11; exp_in = 4'd2;
    start = 1'b1;
    nv = 0;
    for (int c = 0; c < 100 && nv < 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid) nv++;
    end
    chk("t6_reached5", nv, 5);
    rst = 1'b1;
    #1;
    chk("t6_valid", valid, 0);
    chk("t6_eop", eop, 0);
    chk("t6_done", done, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rd_en", rd_en, 0);
    chk("t6_dout", dout_real, 0);
    chk("t6_exp", o_exp, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (eop || done || valid || busy) bad = 1;
    end
    chk("t6_no_eop", bad, 0);
    run_frame(3'd2, f34, 6'd11, 4'd2, 0);
    chk_frame("t6", 12, 2, f34, 2, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
